// File: rtl/ram512x8_fifo_ctrl.sv
// 512x8 FIFO controller driving an external dual-port RAM (write port A, read port B).
// Define RAM_FIFO_ALMOST_FLAGS_EN to add the ALMOST_FULL / ALMOST_EMPTY outputs.
module ram512x8_fifo_ctrl #(
    parameter int unsigned AF_THRESH = 496,
    parameter int unsigned AE_THRESH = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       WR_EN,
    input  logic [7:0] DIN,
    input  logic       RD_EN,
    output logic [7:0] DOUT,
    output logic       DOUT_VALID,
    output logic       FULL,
    output logic       EMPTY,
    output logic [9:0] COUNT,
    output logic       WR_ERR,
    output logic       RD_ERR,
    output logic [8:0] RAM_ADDRA,
    output logic [7:0] RAM_DIA,
    output logic       RAM_ENA,
    output logic       RAM_WEA,
    output logic [8:0] RAM_ADDRB,
    output logic       RAM_ENB,
    output logic       RAM_WEB,
    input  logic [7:0] RAM_DOB,
    output logic       RAM_RSTA,
    output logic       RAM_RSTB
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
   ,output logic       ALMOST_FULL,
    output logic       ALMOST_EMPTY
`endif
);

    logic [8:0] r_wr_ptr;
    logic [8:0] r_rd_ptr;
    logic [9:0] r_count;
    logic       r_full;
    logic       r_empty;
    logic       r_dout_valid;
    logic       r_wr_err;
    logic       r_rd_err;

    logic       w_wr_acc;
    logic       w_rd_acc;
    logic [9:0] w_count_nxt;

    // Acceptance is gated by RST_N so the RAM ports stay idle during reset.
    // Flags are registered, so a full FIFO still accepts a read alongside a rejected write.
    assign w_wr_acc = WR_EN & ~r_full  & RST_N;
    assign w_rd_acc = RD_EN & ~r_empty & RST_N;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + 10'd1;
            2'b01:   w_count_nxt = r_count - 10'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_dout_valid <= 1'b0;
            r_wr_err     <= 1'b0;
            r_rd_err     <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 9'd1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 9'd1;
            r_count      <= w_count_nxt;
            r_full       <= (w_count_nxt == 10'd512);
            r_empty      <= (w_count_nxt == 10'd0);
            r_dout_valid <= w_rd_acc;
            r_wr_err     <= WR_EN & r_full;
            r_rd_err     <= RD_EN & r_empty;
        end
    end

`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    logic r_almost_full;
    logic r_almost_empty;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_count_nxt >= 10'(AF_THRESH));
            r_almost_empty <= (w_count_nxt <= 10'(AE_THRESH));
        end
    end

    assign ALMOST_FULL  = r_almost_full;
    assign ALMOST_EMPTY = r_almost_empty;
`endif

    assign RAM_ADDRA  = r_wr_ptr;
    assign RAM_DIA    = DIN;
    assign RAM_ENA    = w_wr_acc;
    assign RAM_WEA    = w_wr_acc;
    assign RAM_ADDRB  = r_rd_ptr;
    assign RAM_ENB    = w_rd_acc;
    assign RAM_WEB    = 1'b0;
    assign RAM_RSTA   = 1'b0;
    assign RAM_RSTB   = 1'b0;

    assign DOUT       = RAM_DOB;
    assign DOUT_VALID = r_dout_valid;
    assign FULL       = r_full;
    assign EMPTY      = r_empty;
    assign COUNT      = r_count;
    assign WR_ERR     = r_wr_err;
    assign RD_ERR     = r_rd_err;

endmodule

// File: tb/tb_ram512x8_fifo_ctrl.sv
// Randomized bench for ram512x8_fifo_ctrl with a queue-based FIFO model and a behavioural RAM.
module tb_ram512x8_fifo_ctrl;

    localparam int unsigned AF = 496;
    localparam int unsigned AE = 16;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       WR_EN = 1'b0;
    logic [7:0] DIN = '0;
    logic       RD_EN = 1'b0;
    logic [7:0] DOUT;
    logic       DOUT_VALID, FULL, EMPTY, WR_ERR, RD_ERR;
    logic [9:0] COUNT;
    logic [8:0] RAM_ADDRA, RAM_ADDRB;
    logic [7:0] RAM_DIA;
    logic [7:0] RAM_DOB;
    logic       RAM_ENA, RAM_WEA, RAM_ENB, RAM_WEB, RAM_RSTA, RAM_RSTB;
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    logic       ALMOST_FULL, ALMOST_EMPTY;
`endif

    int errors = 0;
    int checks = 0;

    ram512x8_fifo_ctrl #(.AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .DIN(DIN), .RD_EN(RD_EN),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .FULL(FULL), .EMPTY(EMPTY),
        .COUNT(COUNT), .WR_ERR(WR_ERR), .RD_ERR(RD_ERR),
        .RAM_ADDRA(RAM_ADDRA), .RAM_DIA(RAM_DIA), .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA),
        .RAM_ADDRB(RAM_ADDRB), .RAM_ENB(RAM_ENB), .RAM_WEB(RAM_WEB), .RAM_DOB(RAM_DOB),
        .RAM_RSTA(RAM_RSTA), .RAM_RSTB(RAM_RSTB)
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
       ,.ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY)
`endif
    );

    always #5 CLK = ~CLK;

    // Behavioural 512x8 RAM with a registered port-B read.
    logic [7:0] mem [512];
    always @(posedge CLK) begin
        if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= RAM_DIA;
        if (RAM_ENB) RAM_DOB <= mem[RAM_ADDRB];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: contents queue plus pointers counted modulo 512.
    logic [7:0]  q[$];
    int unsigned m_wp = 0, m_rp = 0;
    logic        e_valid = 1'b0, e_werr = 1'b0, e_rerr = 1'b0;
    logic [7:0]  e_dout = '0;

    always @(posedge CLK or negedge RST_N) begin
        bit wa, ra;
        if (!RST_N) begin
            q.delete();
            m_wp = 0; m_rp = 0;
            e_valid = 1'b0; e_werr = 1'b0; e_rerr = 1'b0;
        end else begin
            wa = WR_EN && (q.size() < 512);
            ra = RD_EN && (q.size() != 0);
            e_werr  = WR_EN && !wa;
            e_rerr  = RD_EN && !ra;
            e_valid = ra;
            if (ra) begin e_dout = q.pop_front(); m_rp = (m_rp + 1) % 512; end
            if (wa) begin q.push_back(DIN); m_wp = (m_wp + 1) % 512; end
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            chk("COUNT", int'(COUNT), q.size());
            chk("FULL", int'(FULL), int'(q.size() == 512));
            chk("EMPTY", int'(EMPTY), int'(q.size() == 0));
            chk("WR_ERR", int'(WR_ERR), int'(e_werr));
            chk("RD_ERR", int'(RD_ERR), int'(e_rerr));
            chk("DOUT_VALID", int'(DOUT_VALID), int'(e_valid));
            if (e_valid) chk("DOUT", int'(DOUT), int'(e_dout));
            chk("RAM_WEA", int'(RAM_WEA), int'(WR_EN && q.size() < 512));
            chk("RAM_ENA", int'(RAM_ENA), int'(WR_EN && q.size() < 512));
            chk("RAM_ENB", int'(RAM_ENB), int'(RD_EN && q.size() != 0));
            chk("RAM_ADDRA", int'(RAM_ADDRA), int'(m_wp));
            chk("RAM_ADDRB", int'(RAM_ADDRB), int'(m_rp));
            chk("RAM_DIA", int'(RAM_DIA), int'(DIN));
            chk("RAM_WEB", int'(RAM_WEB), 0);
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
            chk("ALMOST_FULL", int'(ALMOST_FULL), int'(q.size() >= AF));
            chk("ALMOST_EMPTY", int'(ALMOST_EMPTY), int'(q.size() <= AE));
`endif
        end
    end

    // Inputs are applied 1 time unit after an edge and take effect at the next one.
    task automatic cyc(input bit w, input bit r, input logic [7:0] d);
        WR_EN = w; RD_EN = r; DIN = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nw;
        int unsigned occ;
        int unsigned iter;
        bit w, r;

        WR_EN = 1'b1; RD_EN = 1'b1;
        #12;
        chk("rst RAM_ENA", int'(RAM_ENA), 0);
        chk("rst RAM_WEA", int'(RAM_WEA), 0);
        chk("rst RAM_ENB", int'(RAM_ENB), 0);
        chk("rst COUNT", int'(COUNT), 0);
        chk("rst EMPTY", int'(EMPTY), 1);
        chk("rst FULL", int'(FULL), 0);
        chk("rst DOUT_VALID", int'(DOUT_VALID), 0);
        chk("rst WR_ERR", int'(WR_ERR), 0);
        chk("rst RD_ERR", int'(RD_ERR), 0);
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
        chk("rst ALMOST_FULL", int'(ALMOST_FULL), 0);
        chk("rst ALMOST_EMPTY", int'(ALMOST_EMPTY), 1);
`endif
        WR_EN = 1'b0; RD_EN = 1'b0;
        #6 RST_N = 1'b1;

        // Three writes then three back-to-back reads.
        cyc(1, 0, 8'h11);
        chk("first write COUNT", int'(COUNT), 1);
        cyc(1, 0, 8'h22);
        cyc(1, 0, 8'h33);
        chk("three writes COUNT", int'(COUNT), 3);
        cyc(0, 1, 8'h00);
        chk("rd1 DOUT_VALID", int'(DOUT_VALID), 1);
        chk("rd1 DOUT", int'(DOUT), 8'h11);
        cyc(0, 1, 8'h00);
        chk("rd2 DOUT", int'(DOUT), 8'h22);
        cyc(0, 1, 8'h00);
        chk("rd3 DOUT", int'(DOUT), 8'h33);
        chk("drained EMPTY", int'(EMPTY), 1);
        chk("drained COUNT", int'(COUNT), 0);
        cyc(0, 0, 8'h00);
        chk("idle DOUT_VALID", int'(DOUT_VALID), 0);

        // Fill to 512, then one rejected write.
        for (int i = 0; i < 512; i++) begin
            cyc(1, 0, 8'($urandom));
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
            if (i == 494) chk("495 ALMOST_FULL", int'(ALMOST_FULL), 0);
            if (i == 495) chk("496 ALMOST_FULL", int'(ALMOST_FULL), 1);
`endif
        end
        chk("fill FULL", int'(FULL), 1);
        chk("fill COUNT", int'(COUNT), 512);
        WR_EN = 1'b1; DIN = 8'hEE;
        #1;
        chk("overflow RAM_WEA", int'(RAM_WEA), 0);
        cyc(1, 0, 8'hEE);
        chk("overflow WR_ERR", int'(WR_ERR), 1);
        chk("overflow COUNT", int'(COUNT), 512);
        cyc(0, 0, 8'h00);
        chk("WR_ERR one cycle", int'(WR_ERR), 0);

        // Full with both requests: read wins.
        cyc(1, 1, 8'hAB);
        chk("full both WR_ERR", int'(WR_ERR), 1);
        chk("full both COUNT", int'(COUNT), 511);
        chk("full both FULL", int'(FULL), 0);
        chk("full both DOUT_VALID", int'(DOUT_VALID), 1);
        while (q.size() > 0) begin
            cyc(0, 1, 8'h00);
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
            if (q.size() == 17) chk("17 ALMOST_EMPTY", int'(ALMOST_EMPTY), 0);
            if (q.size() == 16) chk("16 ALMOST_EMPTY", int'(ALMOST_EMPTY), 1);
`endif
        end
        chk("drain COUNT", int'(COUNT), 0);

        // Empty with both requests: write wins.
        cyc(1, 1, 8'h5A);
        chk("empty both RD_ERR", int'(RD_ERR), 1);
        chk("empty both COUNT", int'(COUNT), 1);
        chk("empty both DOUT_VALID", int'(DOUT_VALID), 0);
        cyc(0, 1, 8'h00);
        chk("empty both data", int'(DOUT), 8'h5A);

        // Interleaved traffic at low occupancy; pointers wrap several times.
        nw = 0; iter = 0;
        while ((nw < 1000 || q.size() > 0) && iter < 20000) begin
            occ = q.size();
            if (nw >= 1000) begin
                w = 0; r = (occ > 0);
            end else begin
                r = (occ >= 4) || (occ >= 2 && $urandom_range(0, 1) == 1);
                w = (occ < 4) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
                if (occ == 0) w = 1;
            end
            if (w) nw++;
            cyc(w, r, 8'($urandom));
            iter++;
        end
        chk("interleave finished", int'(iter < 20000), 1);
        chk("interleave EMPTY", int'(EMPTY), 1);

        // Asynchronous reset with 100 entries stored.
        for (int i = 0; i < 100; i++) cyc(1, 0, 8'($urandom));
        chk("pre-reset COUNT", int'(COUNT), 100);
        #2 RST_N = 1'b0;
        #1;
        chk("async rst COUNT", int'(COUNT), 0);
        chk("async rst EMPTY", int'(EMPTY), 1);
        chk("async rst FULL", int'(FULL), 0);
        WR_EN = 1'b1; RD_EN = 1'b1;
        #1;
        chk("async rst RAM_ENA", int'(RAM_ENA), 0);
        chk("async rst RAM_ENB", int'(RAM_ENB), 0);
        @(posedge CLK);
        #1;
        WR_EN = 1'b0; RD_EN = 1'b0;
        chk("held rst COUNT", int'(COUNT), 0);
        #2 RST_N = 1'b1;
        cyc(0, 1, 8'h00);
        chk("post-reset RD_ERR", int'(RD_ERR), 1);
        chk("post-reset DOUT_VALID", int'(DOUT_VALID), 0);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram512x8_fifo_ctrl.md
RAM512X8_FIFO_CTRL -- requirements
Module: ram512x8_fifo_ctrl

Interface
REQ-001 The block SHALL operate on one clock; reset SHALL be asynchronous and active-low; ports CLK and RST_N.
REQ-002 Parameter AF_THRESH, default 496, almost-full threshold in entries (used only with the Configuration macro).
REQ-003 Parameter AE_THRESH, default 16, almost-empty threshold in entries (used only with the Configuration macro).
REQ-004 CLK  input  1  rising-edge clock, shared with both RAM ports.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 WR_EN  input  1  write request.
REQ-007 DIN  input  8  write data.
REQ-008 RD_EN  input  1  read request.
REQ-009 DOUT  output  8  read data, driven directly from RAM_DOB.
REQ-010 DOUT_VALID  output  1  DOUT holds data from the read accepted one cycle earlier.
REQ-011 FULL / EMPTY  output  1 each  registered occupancy flags.
REQ-012 COUNT  output  10  occupancy, 0..512.
REQ-013 WR_ERR / RD_ERR  output  1 each  one-cycle pulse on a rejected write or read.
REQ-014 RAM_ADDRA  output  9, RAM_DIA  output  8, RAM_ENA  output  1, RAM_WEA  output  1: 512x8 dual-port RAM write port A.
REQ-015 RAM_ADDRB  output  9, RAM_ENB  output  1, RAM_WEB  output  1, RAM_DOB  input  8: RAM read port B.
REQ-016 RAM_RSTA / RAM_RSTB  output  1 each  RAM output resets, tied to 0.

Function
REQ-017 A write SHALL be accepted when WR_EN=1 and FULL=0; RAM_ENA=RAM_WEA=accept (combinational), RAM_ADDRA=wr_ptr, RAM_DIA=DIN.
REQ-018 A read SHALL be accepted when RD_EN=1 and EMPTY=0; RAM_ENB=accept (combinational), RAM_ADDRB=rd_ptr, RAM_WEB=0.
REQ-019 wr_ptr and rd_ptr SHALL be 9 bits, incrementing by 1 on each accepted operation and wrapping 511->0.
REQ-020 COUNT SHALL increment on write-only, decrement on read-only, and stay unchanged on a simultaneous accepted write and read.
REQ-021 FULL SHALL equal (next COUNT==512) and EMPTY SHALL equal (next COUNT==0), both registered.
REQ-022 When full, simultaneous WR_EN and RD_EN SHALL accept the read and reject the write (WR_ERR=1); COUNT becomes 511.
REQ-023 When empty, simultaneous WR_EN and RD_EN SHALL accept the write and reject the read (RD_ERR=1); COUNT becomes 1.
REQ-024 DOUT_VALID SHALL be 1 exactly in the cycle after an accepted read (latency 1); DOUT is don't-care when DOUT_VALID=0.
REQ-025 Read-during-write to the same address SHALL not occur: a read is accepted only from an entry written in an earlier cycle.
REQ-026 WR_ERR/RD_ERR SHALL be registered and asserted for one cycle per rejected request.

Reset
REQ-027 RST_N=0 SHALL immediately clear wr_ptr, rd_ptr, COUNT=0, DOUT_VALID=0, FULL=0, EMPTY=1, WR_ERR=RD_ERR=0, ALMOST_FULL=0, ALMOST_EMPTY=1.
REQ-028 While RST_N=0, RAM_ENA, RAM_WEA and RAM_ENB SHALL be 0; RAM contents are not cleared.
REQ-029 Reset mid-operation SHALL discard all stored entries and any pending DOUT_VALID.
REQ-030 The first request SHALL be accepted on the first rising CLK edge after RST_N deasserts.

Configuration
REQ-031 With macro RAM_FIFO_ALMOST_FLAGS_EN defined, outputs ALMOST_FULL (registered, next COUNT>=AF_THRESH) and ALMOST_EMPTY (registered, next COUNT<=AE_THRESH) SHALL exist.
REQ-032 Without RAM_FIFO_ALMOST_FLAGS_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset, write 0x11,0x22,0x33, then read 3 -> DOUT 0x11,0x22,0x33 each one cycle after the accepted read; EMPTY=1 and COUNT=0 at end.
REQ-034 Write 512 entries -> FULL=1, COUNT=512; 513th write -> WR_ERR pulse, COUNT stays 512, RAM_WEA=0.
REQ-035 Full, WR_EN=RD_EN=1 -> read accepted, WR_ERR=1, COUNT=511, FULL=0; empty, both asserted -> RD_ERR=1, COUNT=1.
REQ-036 Drive 1000 writes and reads interleaved with occupancy kept at 1..4 -> pointers wrap past 511; data order is preserved end to end.
REQ-037 RST_N low after 100 writes -> COUNT=0 and EMPTY=1 asynchronously; the next read gives RD_ERR=1.
REQ-038 With RAM_FIFO_ALMOST_FLAGS_EN, write 496 entries -> ALMOST_FULL=1 in the next cycle; read down to 16 -> ALMOST_EMPTY=1.
